// File: rtl/led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_pattern_gen                                              |
// | Description : WIDTH-bit LED driver with static/blink/rotate/bounce         |
// |               patterns stepped by a prescaler tick and a PWM brightness    |
// |               gate on the registered output.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module led_pattern_gen #(
    parameter int              WIDTH    = 8,
    parameter int              DIV      = 12000000,
    parameter int              PWM_BITS = 4,
    parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    pattern,
    input  logic                load,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [WIDTH-1:0]    LPORT,
    output logic                tick
);

    localparam int C_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int C_POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0]  C_PRESC_MAX = C_CNT_W'(DIV - 1);
    localparam logic [C_POS_W-1:0]  C_POS_MAX   = C_POS_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_POS_W-1:0]  C_POS_ONE   = C_POS_W'(1);
    localparam logic [PWM_BITS-1:0] C_PWM_ONE   = PWM_BITS'(1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [WIDTH-1:0]    pat_q, pat_d;
    logic [C_CNT_W-1:0]  presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                blink_ph_q, blink_ph_d;
    logic [C_POS_W-1:0]  pos_q, pos_d;
    dir_e                dir_q, dir_d;
    mode_e               mode_q, mode_d;
    logic [WIDTH-1:0]    lport_q, lport_d;
    logic                tick_q, tick_d;

    logic                w_wrap;
    logic                w_mode_chg;
    logic                w_pwm_on;
    logic [WIDTH-1:0]    w_pat_rot;
    logic [WIDTH-1:0]    w_onehot;
    logic [WIDTH-1:0]    w_frame;

    assign w_wrap     = (presc_q == C_PRESC_MAX);
    assign w_mode_chg = (mode_e'(mode) != mode_q);
    assign w_pwm_on   = (brightness == {PWM_BITS{1'b1}}) || (pwm_cnt_q < brightness);

    // A single LED has nothing to rotate into.
    generate
        if (WIDTH > 1) begin : g_rot_multi
            assign w_pat_rot = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        end else begin : g_rot_single
            assign w_pat_rot = pat_q;
        end
    endgenerate

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_onehot[i] = (pos_q == C_POS_W'(i));
        end
    end

    always_comb begin
        w_frame = pat_q;
        case (mode_q)
            MODE_BLINK:  w_frame = blink_ph_q ? pat_q : '0;
            MODE_BOUNCE: w_frame = w_onehot;
            default:     w_frame = pat_q;
        endcase
    end

    always_comb begin
        pat_d      = pat_q;
        presc_d    = w_wrap ? '0 : (presc_q + C_CNT_ONE);
        pwm_cnt_d  = pwm_cnt_q + C_PWM_ONE;
        blink_ph_d = blink_ph_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        mode_d     = mode_e'(mode);
        tick_d     = w_wrap && !load;
        lport_d    = w_frame & {WIDTH{w_pwm_on}};

        // Load outranks a mode change, which outranks a pattern step.
        if (load) begin
            pat_d      = pattern;
            presc_d    = '0;
            blink_ph_d = 1'b1;
            pos_d      = '0;
            dir_d      = DIR_UP;
        end else if (w_mode_chg) begin
            blink_ph_d = 1'b1;
            pos_d      = '0;
            dir_d      = DIR_UP;
        end else if (w_wrap) begin
            case (mode_q)
                MODE_BLINK:  blink_ph_d = !blink_ph_q;
                MODE_ROTATE: pat_d      = w_pat_rot;
                MODE_BOUNCE: begin
                    if (WIDTH > 1) begin
                        if (dir_q == DIR_UP) begin
                            pos_d = pos_q + C_POS_ONE;
                            if (pos_d == C_POS_MAX) dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q - C_POS_ONE;
                            if (pos_d == '0) dir_d = DIR_UP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q      <= INIT;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            blink_ph_q <= 1'b1;
            pos_q      <= '0;
            dir_q      <= DIR_UP;
            mode_q     <= MODE_STATIC;
            lport_q    <= '0;
            tick_q     <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            blink_ph_q <= blink_ph_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            lport_q    <= lport_d;
            tick_q     <= tick_d;
        end
    end

    assign LPORT = lport_q;
    assign tick  = tick_q;

endmodule
`default_nettype wire
